pc_predict_unit: RTL and testbench

- Front-end control block of the 5-stage RV32I pipeline (IF/ID/EX/MA/RW).
- Three functions:
  - Branch-target predictor (BTB with 2-bit counters): supplies the next fetch PC in IF and learns from EX.
  - Next-PC generator: resolves the actual next PC in EX.
  - Operand switcher: selects the ALU operands in ID.
- Only the predictor is clocked; the other two are purely combinational.

---
 rtl/pc_predict_unit.sv | 141 ++++++++++++++
 tb/tb_pc_predict_unit.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/pc_predict_unit.sv
// Front-end PC control: BTB predictor (IF), next-PC resolve (EX), ALU operand select (ID).
// Latency: npc_predict/npc/oprl/oprr are combinational; BTB learning visible one cycle after the update edge.
// Backpressure: none; the pipeline drives one IF/EX/ID slot per cycle and pc_ex==0 marks an EX bubble.
//
// Ports:
//   clk, nrst                          clock, synchronous active-low reset
//   pc_if -> npc_predict               IF-stage prediction
//   pc_ex, npc_ex_actual,
//   is_taken_actual                    EX-stage BTB training
//   alucode, npc_default, npc_branch,
//   npc_jalr, br_taken -> npc          EX-stage next-PC resolve
//   aluop1_type, aluop2_type, pc_id,
//   regdata1, regdata2, imm -> oprl/oprr  ID-stage operand select
module pc_predict_unit #(
    parameter int         BTB_IDX_BITS = 6,
    parameter logic [5:0] ALU_JAL      = 6'd46,
    parameter logic [5:0] ALU_JALR     = 6'd47
) (
    input  logic        clk,
    input  logic        nrst,
    input  logic [15:0] pc_if,
    output logic [31:0] npc_predict,
    input  logic [15:0] pc_ex,
    input  logic [15:0] npc_ex_actual,
    input  logic        is_taken_actual,
    input  logic [5:0]  alucode,
    input  logic [31:0] npc_default,
    input  logic [31:0] npc_branch,
    input  logic [31:0] npc_jalr,
    input  logic        br_taken,
    output logic [31:0] npc,
    input  logic [1:0]  aluop1_type,
    input  logic [1:0]  aluop2_type,
    input  logic [31:0] pc_id,
    input  logic [31:0] regdata1,
    input  logic [31:0] regdata2,
    input  logic [31:0] imm,
    output logic [31:0] oprl,
    output logic [31:0] oprr
);

    localparam int ENTRIES = 1 << BTB_IDX_BITS;
    localparam int TAG_W   = 16 - BTB_IDX_BITS - 2;

    localparam logic [1:0] OP_NONE = 2'd0;
    localparam logic [1:0] OP_REG  = 2'd1;
    localparam logic [1:0] OP_IMM  = 2'd2;
    localparam logic [1:0] OP_PC   = 2'd3;

    // ---------------- operand switcher ----------------
    always_comb begin
        oprl = 32'h0;
        case (aluop1_type)
            OP_NONE: oprl = 32'h0;
            OP_REG:  oprl = regdata1;
            OP_IMM:  oprl = imm;
            OP_PC:   oprl = pc_id;
            default: oprl = 32'h0;
        endcase
    end

    always_comb begin
        oprr = 32'h0;
        case (aluop2_type)
            OP_NONE: oprr = 32'h0;
            OP_REG:  oprr = regdata2;
            OP_IMM:  oprr = imm;
            OP_PC:   oprr = pc_id;
            default: oprr = 32'h0;
        endcase
    end

    // ---------------- next-PC generator ----------------
    // JALR target must be halfword-aligned, so bit 0 is forced low.
    always_comb begin
        npc = npc_default;
        if (alucode == ALU_JALR) begin
            npc = npc_jalr & ~32'h1;
        end else if ((alucode == ALU_JAL) || br_taken) begin
            npc = npc_branch;
        end
    end

    // ---------------- branch target buffer ----------------
    logic             btb_valid  [ENTRIES];
    logic [TAG_W-1:0] btb_tag    [ENTRIES];
    logic [15:0]      btb_target [ENTRIES];
    logic [1:0]       btb_cnt    [ENTRIES];

    logic [BTB_IDX_BITS-1:0] idx_if;
    logic [TAG_W-1:0]        tag_if;
    logic [15:0]             pc_if_inc;
    logic                    pred_hit;

    assign idx_if    = pc_if[BTB_IDX_BITS+1:2];
    assign tag_if    = pc_if[15:BTB_IDX_BITS+2];
    assign pc_if_inc = pc_if + 16'd4;

    // Only weakly/strongly taken entries redirect fetch (cnt >= 2 is cnt[1]).
    assign pred_hit    = btb_valid[idx_if] && (btb_tag[idx_if] == tag_if) && btb_cnt[idx_if][1];
    assign npc_predict = pred_hit ? {16'h0, btb_target[idx_if]} : {16'h0, pc_if_inc};

    logic [BTB_IDX_BITS-1:0] idx_ex;
    logic [TAG_W-1:0]        tag_ex;
    logic [15:0]             pc_ex_inc;
    logic                    ex_hit;
    logic                    taken_eff;

    assign idx_ex    = pc_ex[BTB_IDX_BITS+1:2];
    assign tag_ex    = pc_ex[15:BTB_IDX_BITS+2];
    assign pc_ex_inc = pc_ex + 16'd4;
    assign ex_hit    = btb_valid[idx_ex] && (btb_tag[idx_ex] == tag_ex);
    // Any redirect away from the fall-through (jumps included) trains as taken.
    assign taken_eff = is_taken_actual || (npc_ex_actual != pc_ex_inc);

    always_ff @(posedge clk) begin
        if (!nrst) begin
            for (int i = 0; i < ENTRIES; i++) begin
                btb_valid[i]  <= 1'b0;
                btb_tag[i]    <= '0;
                btb_target[i] <= 16'h0;
                btb_cnt[i]    <= 2'd1;
            end
        end else if (pc_ex != 16'h0) begin
            if (ex_hit) begin
                if (taken_eff) begin
                    if (btb_cnt[idx_ex] != 2'd3) btb_cnt[idx_ex] <= btb_cnt[idx_ex] + 2'd1;
                    btb_target[idx_ex] <= npc_ex_actual;
                end else if (btb_cnt[idx_ex] != 2'd0) begin
                    btb_cnt[idx_ex] <= btb_cnt[idx_ex] - 2'd1;
                end
            end else if (taken_eff) begin
                btb_valid[idx_ex]  <= 1'b1;
                btb_tag[idx_ex]    <= tag_ex;
                btb_target[idx_ex] <= npc_ex_actual;
                btb_cnt[idx_ex]    <= 2'd2;
            end
        end
    end

endmodule

// File: tb/tb_pc_predict_unit.sv
module tb_pc_predict_unit;

    localparam int IDX = 6;
    localparam int N   = 1 << IDX;

    logic        clk = 1'b0;
    logic        nrst;
    logic [15:0] pc_if;
    logic [31:0] npc_predict;
    logic [15:0] pc_ex;
    logic [15:0] npc_ex_actual;
    logic        is_taken_actual;
    logic [5:0]  alucode;
    logic [31:0] npc_default, npc_branch, npc_jalr;
    logic        br_taken;
    logic [31:0] npc;
    logic [1:0]  aluop1_type, aluop2_type;
    logic [31:0] pc_id, regdata1, regdata2, imm;
    logic [31:0] oprl, oprr;

    int checks   = 0;
    int failures = 0;

    // Reference BTB: one record per index, addressed by plain arithmetic on the PC.
    bit m_valid [N];
    int m_tag   [N];
    int m_tgt   [N];
    int m_cnt   [N];

    pc_predict_unit #(.BTB_IDX_BITS(IDX), .ALU_JAL(6'd46), .ALU_JALR(6'd47)) dut (
        .clk(clk), .nrst(nrst),
        .pc_if(pc_if), .npc_predict(npc_predict),
        .pc_ex(pc_ex), .npc_ex_actual(npc_ex_actual), .is_taken_actual(is_taken_actual),
        .alucode(alucode), .npc_default(npc_default), .npc_branch(npc_branch),
        .npc_jalr(npc_jalr), .br_taken(br_taken), .npc(npc),
        .aluop1_type(aluop1_type), .aluop2_type(aluop2_type), .pc_id(pc_id),
        .regdata1(regdata1), .regdata2(regdata2), .imm(imm),
        .oprl(oprl), .oprr(oprr)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    function automatic int m_predict(input int pc);
        int i, t;
        i = (pc / 4) % N;
        t = pc / (4 * N);
        if (m_valid[i] && m_tag[i] == t && m_cnt[i] >= 2) return m_tgt[i];
        return (pc + 4) % 65536;
    endfunction

    task automatic m_update(input bit rst_n, input int pcx, input int nx, input bit tk);
        int i, t;
        bit teff;
        if (!rst_n) begin
            for (int k = 0; k < N; k++) begin
                m_valid[k] = 0; m_tag[k] = 0; m_tgt[k] = 0; m_cnt[k] = 1;
            end
        end else if (pcx != 0) begin
            i = (pcx / 4) % N;
            t = pcx / (4 * N);
            teff = tk || (nx != (pcx + 4) % 65536);
            if (m_valid[i] && m_tag[i] == t) begin
                if (teff) begin
                    m_cnt[i] = (m_cnt[i] < 3) ? m_cnt[i] + 1 : 3;
                    m_tgt[i] = nx;
                end else begin
                    m_cnt[i] = (m_cnt[i] > 0) ? m_cnt[i] - 1 : 0;
                end
            end else if (teff) begin
                m_valid[i] = 1; m_tag[i] = t; m_tgt[i] = nx; m_cnt[i] = 2;
            end
        end
    endtask

    function automatic logic [31:0] m_opr(input int ty, input logic [31:0] r, input logic [31:0] im,
                                          input logic [31:0] pc);
        if (ty == 1) return r;
        if (ty == 2) return im;
        if (ty == 3) return pc;
        return 32'h0;
    endfunction

    function automatic logic [31:0] m_npc();
        if (alucode == 6'd47) return {npc_jalr[31:1], 1'b0};
        if (alucode == 6'd46 || br_taken) return npc_branch;
        return npc_default;
    endfunction

    // One predictor cycle: inputs applied after a falling edge, prediction checked
    // before the rising edge, model advanced with the same inputs at the edge.
    task automatic cycle(input bit rst_n, input logic [15:0] pi, input logic [15:0] px,
                         input logic [15:0] nx, input bit tk, input bit do_chk,
                         input bit use_dir, input logic [31:0] dir_exp);
        nrst = rst_n; pc_if = pi; pc_ex = px; npc_ex_actual = nx; is_taken_actual = tk;
        #1;
        if (do_chk) chk("predict_model", npc_predict, m_predict(int'(pi)));
        if (use_dir) chk("predict_dir", npc_predict, dir_exp);
        @(posedge clk);
        m_update(rst_n, int'(px), int'(nx), tk);
        @(negedge clk);
    endtask

    logic [31:0] exp_l [4];
    logic [31:0] exp_r [4];

    initial begin
        nrst = 1'b0; pc_if = 16'h0; pc_ex = 16'h0; npc_ex_actual = 16'h0; is_taken_actual = 1'b0;
        alucode = 6'd0; npc_default = 32'h0; npc_branch = 32'h0; npc_jalr = 32'h0; br_taken = 1'b0;
        aluop1_type = 2'd0; aluop2_type = 2'd0; pc_id = 32'h0; regdata1 = 32'h0; regdata2 = 32'h0; imm = 32'h0;
        @(negedge clk);

        // Operand switcher sweep
        regdata1 = 32'h11; regdata2 = 32'h22; imm = 32'h33; pc_id = 32'h8004;
        exp_l[0] = 32'h0; exp_l[1] = 32'h11; exp_l[2] = 32'h33; exp_l[3] = 32'h8004;
        exp_r[0] = 32'h0; exp_r[1] = 32'h22; exp_r[2] = 32'h33; exp_r[3] = 32'h8004;
        for (int a = 0; a < 4; a++) begin
            for (int b = 0; b < 4; b++) begin
                aluop1_type = 2'(a); aluop2_type = 2'(b);
                #1;
                chk("oprl_sweep", oprl, exp_l[a]);
                chk("oprr_sweep", oprr, exp_r[b]);
            end
        end

        // Next-PC directed
        npc_default = 32'h8004; npc_branch = 32'h8040; npc_jalr = 32'h8101; br_taken = 1'b0;
        alucode = 6'd47; #1; chk("npc_jalr", npc, 32'h8100);
        alucode = 6'd46; #1; chk("npc_jal", npc, 32'h8040);
        alucode = 6'd10; #1; chk("npc_br_nt", npc, 32'h8004);
        br_taken = 1'b1; #1; chk("npc_br_t", npc, 32'h8040);

        // Randomized combinational checks
        for (int k = 0; k < 60; k++) begin
            aluop1_type = 2'($urandom_range(0, 3)); aluop2_type = 2'($urandom_range(0, 3));
            regdata1 = $urandom; regdata2 = $urandom; imm = $urandom; pc_id = $urandom;
            alucode = 6'($urandom_range(44, 49)); br_taken = 1'($urandom_range(0, 1));
            npc_default = $urandom; npc_branch = $urandom; npc_jalr = $urandom;
            #1;
            chk("oprl_rand", oprl, m_opr(int'(aluop1_type), regdata1, imm, pc_id));
            chk("oprr_rand", oprr, m_opr(int'(aluop2_type), regdata2, imm, pc_id));
            chk("npc_rand", npc, m_npc());
        end

        @(negedge clk);
        // Reset with an update presented: must be ignored
        cycle(0, 16'h8000, 16'h8000, 16'h8040, 1, 0, 0, 32'h0);
        cycle(1, 16'h8000, 16'h8000, 16'h8040, 1, 1, 1, 32'h8004); // allocate, old entry seen
        cycle(1, 16'h8000, 16'h8000, 16'h8040, 1, 1, 1, 32'h8040); // cnt 2->3
        cycle(1, 16'h8000, 16'h8000, 16'h8040, 1, 1, 1, 32'h8040); // saturate at 3
        cycle(1, 16'h8000, 16'h8000, 16'h8004, 0, 1, 1, 32'h8040); // 3->2
        cycle(1, 16'h8000, 16'h8000, 16'h8004, 0, 1, 1, 32'h8040); // 2->1
        cycle(1, 16'h8000, 16'h0000, 16'h0000, 0, 1, 1, 32'h8004);
        cycle(1, 16'h8000, 16'h8000, 16'h8040, 1, 1, 1, 32'h8004); // 1->2
        cycle(1, 16'h8100, 16'h0000, 16'h1234, 1, 1, 1, 32'h8104); // alias miss, bubble update
        cycle(1, 16'h8000, 16'h0000, 16'h0000, 0, 1, 1, 32'h8040); // entry untouched
        cycle(0, 16'h8000, 16'h8000, 16'h8040, 1, 1, 1, 32'h8040); // reset mid-run
        cycle(1, 16'h8000, 16'h0000, 16'h0000, 0, 1, 1, 32'h8004);
        cycle(1, 16'hFFFC, 16'h0000, 16'h0000, 0, 1, 1, 32'h0000); // 16-bit wrap

        // Randomized predictor traffic on a small PC pool to force hits and aliases
        for (int k = 0; k < 600; k++) begin
            logic [15:0] pi, px, nx;
            bit rn, tk;
            pi = 16'h8000 | 16'($urandom_range(0, 7) << 2) | 16'($urandom_range(0, 1) << 8);
            if ($urandom_range(0, 9) == 0) pi = 16'($urandom);
            px = 16'h8000 | 16'($urandom_range(0, 7) << 2) | 16'($urandom_range(0, 1) << 8);
            if ($urandom_range(0, 4) == 0) px = 16'h0;
            nx = ($urandom_range(0, 1) == 0) ? px + 16'd4 : (16'h9000 | 16'($urandom_range(0, 255) << 2));
            tk = ($urandom_range(0, 3) == 0);
            rn = ($urandom_range(0, 49) != 0);
            cycle(rn, pi, px, nx, tk, 1, 0, 32'h0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
